// File: rtl/stack_port_arbiter_if.sv
// Client-side bus of the stack port arbiter: two requesters A and B
// plus the shared response data and error flag.
interface stack_port_arbiter_if #(
  parameter int DW = 4,
  parameter int IW = 3
);
  logic          req_a;
  logic [1:0]    cmd_a;
  logic [IW-1:0] idx_a;
  logic [DW-1:0] wdata_a;
  logic          ack_a;
  logic          rvalid_a;
  logic          req_b;
  logic [1:0]    cmd_b;
  logic [IW-1:0] idx_b;
  logic [DW-1:0] wdata_b;
  logic          ack_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata;
  logic          rerr;

  modport master (
    output req_a, cmd_a, idx_a, wdata_a,
    output req_b, cmd_b, idx_b, wdata_b,
    input  ack_a, rvalid_a, ack_b, rvalid_b,
    input  rdata, rerr
  );

  modport slave (
    input  req_a, cmd_a, idx_a, wdata_a,
    input  req_b, cmd_b, idx_b, wdata_b,
    output ack_a, rvalid_a, ack_b, rvalid_b,
    output rdata, rerr
  );
endinterface

// File: rtl/stack_port_arbiter.sv
// Two-client arbiter/sequencer for a shared circular stack.
// Define STACK_ARB_FIXED_PRIO_EN for fixed priority (A wins) instead of round-robin.
module stack_port_arbiter #(
  parameter int DEPTH = 5,
  parameter int DW    = 4,
  parameter int IW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  stack_port_arbiter_if.slave cl,
  output logic [1:0]    stk_cmd,
  output logic [IW-1:0] stk_index,
  output logic [DW-1:0] stk_wdata,
  output logic          stk_wen,
  input  logic [DW-1:0] stk_rdata,
  output logic          stk_clr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int XW = (IW > CW) ? IW : CW;

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_PUSH = 2'b01;
  localparam logic [1:0] C_POP  = 2'b10;
  localparam logic [1:0] C_GET  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] count;
  logic          owner_b;
  logic [1:0]    cmd_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;

  logic          grant_a, grant_b;
  logic          idle, hs, pass;
  logic [1:0]    sel_cmd;
  logic [IW-1:0] sel_idx;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;
  logic [XW-1:0] idx_x, cnt_x;

`ifdef STACK_ARB_FIXED_PRIO_EN
  assign grant_a = cl.req_a;
  assign grant_b = cl.req_b & ~cl.req_a;
`else
  // last_b: 1 when B owned the most recent handshake
  logic last_b;

  assign grant_a = cl.req_a & (~cl.req_b | last_b);
  assign grant_b = cl.req_b & (~cl.req_a | ~last_b);

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_b <= 1'b1;
    end else if (hs) begin
      last_b <= grant_b;
    end
  end
`endif

  assign idle = (state_q == S_IDLE);
  assign hs   = idle & reset & (grant_a | grant_b);

  assign cl.ack_a = idle & reset & grant_a;
  assign cl.ack_b = idle & reset & grant_b;

  assign sel_cmd   = grant_b ? cl.cmd_b   : cl.cmd_a;
  assign sel_idx   = grant_b ? cl.idx_b   : cl.idx_a;
  assign sel_wdata = grant_b ? cl.wdata_b : cl.wdata_a;

  assign idx_x = XW'(sel_idx);
  assign cnt_x = XW'(count);

  always_comb begin
    sel_err = 1'b0;
    unique case (1'b1)
      sel_cmd == C_PUSH: sel_err = (count == CW'(DEPTH));
      sel_cmd == C_POP:  sel_err = (count == '0);
      sel_cmd == C_GET:  sel_err = (idx_x >= cnt_x);
      default:           sel_err = 1'b0;
    endcase
  end

  // Rejected ops and NOPs skip ISSUE so they never touch the stack
  assign pass = (sel_cmd != C_NOP) & ~sel_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d = pass ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    stk_clr <= ~reset;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      owner_b <= 1'b0;
      cmd_q   <= C_NOP;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (hs) begin
        owner_b <= grant_b;
        cmd_q   <= sel_cmd;
        idx_q   <= sel_idx;
        wdata_q <= sel_wdata;
        err_q   <= sel_err;
        if (!pass) begin
          rdata_q <= '0;
        end
      end
      if (state_q == S_ISSUE) begin
        unique case (cmd_q)
          C_PUSH: begin
            count   <= count + CW'(1);
            rdata_q <= '0;
          end
          C_POP: begin
            count   <= count - CW'(1);
            rdata_q <= stk_rdata;
          end
          C_GET: begin
            rdata_q <= stk_rdata;
          end
          default: begin
            rdata_q <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    stk_cmd   = C_NOP;
    stk_index = '0;
    stk_wdata = '0;
    stk_wen   = 1'b0;
    if (state_q == S_ISSUE) begin
      stk_cmd = cmd_q;
      if (cmd_q == C_GET) begin
        stk_index = idx_q;
      end
      if (cmd_q == C_PUSH) begin
        stk_wen   = 1'b1;
        stk_wdata = wdata_q;
      end
    end
  end

  assign cl.rvalid_a = (state_q == S_RESP) & ~owner_b;
  assign cl.rvalid_b = (state_q == S_RESP) & owner_b;
  assign cl.rerr     = (state_q == S_RESP) & err_q;
  assign cl.rdata    = rdata_q;

endmodule

// File: tb/tb_stack_port_arbiter.sv
// Directed bench for stack_port_arbiter with a small behavioural stack
// attached to the STK_* pins.
module tb_stack_port_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] stk_cmd;
  logic [2:0] stk_index;
  logic [3:0] stk_wdata;
  logic       stk_wen;
  logic [3:0] stk_rdata;
  logic       stk_clr;

  int n_cmp;
  int n_bad;

  stack_port_arbiter_if #(.DW(4), .IW(3)) bus ();

  stack_port_arbiter #(.DEPTH(5), .DW(4), .IW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .cl        (bus),
    .stk_cmd   (stk_cmd),
    .stk_index (stk_index),
    .stk_wdata (stk_wdata),
    .stk_wen   (stk_wen),
    .stk_rdata (stk_rdata),
    .stk_clr   (stk_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: index 0 is the top entry
  logic [3:0] mem [0:4];
  int sp;
  int pos;

  initial sp = 0;

  always @(posedge clk) begin
    if (stk_clr) begin
      sp <= 0;
    end else if (stk_cmd == 2'b01) begin
      mem[sp % 5] <= stk_wdata;
      sp <= sp + 1;
    end else if (stk_cmd == 2'b10) begin
      sp <= sp - 1;
    end
  end

  always_comb begin
    pos = sp - 1;
    if (stk_cmd == 2'b11) pos = sp - 1 - int'(stk_index);
    stk_rdata = 4'h0;
    if ((stk_cmd[1] == 1'b1) && (pos >= 0)) stk_rdata = mem[pos % 5];
  end

  task automatic idle_inputs();
    bus.req_a = 0; bus.cmd_a = 0; bus.idx_a = 0; bus.wdata_a = 0;
    bus.req_b = 0; bus.cmd_b = 0; bus.idx_b = 0; bus.wdata_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
  endtask

  // Issues one op and records what the DUT did; callers compare.
  task automatic issue(
    input  bit         b,
    input  logic [1:0] c,
    input  logic [2:0] i,
    input  logic [3:0] w,
    output bit         ack,
    output logic [1:0] scmd,
    output bit         swen,
    output logic [3:0] swd,
    output int         lat,
    output bit         err,
    output logic [3:0] rd
  );
    if (b) begin
      bus.req_b = 1; bus.cmd_b = c; bus.idx_b = i; bus.wdata_b = w;
    end else begin
      bus.req_a = 1; bus.cmd_a = c; bus.idx_a = i; bus.wdata_a = w;
    end
    @(negedge clk);
    ack = b ? bus.ack_b : bus.ack_a;
    @(posedge clk); #1;
    idle_inputs();
    scmd = 0; swen = 0; swd = 0; lat = 0; err = 0; rd = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        scmd = stk_cmd; swen = stk_wen; swd = stk_wdata;
      end
      if (b ? bus.rvalid_b : bus.rvalid_a) begin
        lat = k; err = bus.rerr; rd = bus.rdata;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  bit ack, swen, err;
  logic [1:0] scmd;
  logic [3:0] swd, rd;
  int lat;

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    bus.req_a = 1; bus.cmd_a = 2'b01;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (bus.ack_a !== 1'b0) begin n_bad++; $display("FAIL rst_ack got=%0b want=0", bus.ack_a); end
    n_cmp++; if (stk_clr !== 1'b1) begin n_bad++; $display("FAIL rst_clr got=%0b want=1", stk_clr); end
    n_cmp++; if (stk_cmd !== 2'b00) begin n_bad++; $display("FAIL rst_stkcmd got=%0b want=00", stk_cmd); end
    n_cmp++; if ({bus.rvalid_a, bus.rvalid_b, bus.rerr, stk_wen} !== 4'b0) begin n_bad++; $display("FAIL rst_outs got=%0b want=0", {bus.rvalid_a, bus.rvalid_b, bus.rerr, stk_wen}); end
    n_cmp++; if (bus.rdata !== 4'h0) begin n_bad++; $display("FAIL rst_rdata got=%0h want=0", bus.rdata); end
    n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d want=0", dut.count); end
    idle_inputs();
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (stk_clr !== 1'b0) begin n_bad++; $display("FAIL clr_release got=%0b want=0", stk_clr); end
    @(posedge clk); #1;
  endtask

  task automatic test_push();
    do_reset();
    issue(0, 2'b01, 3'd0, 4'h3, ack, scmd, swen, swd, lat, err, rd);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL push3_ack got=%0b want=1", ack); end
    n_cmp++; if ({scmd, swen, swd} !== {2'b01, 1'b1, 4'h3}) begin n_bad++; $display("FAIL push3_stk got=%b want=0110011", {scmd, swen, swd}); end
    n_cmp++; if ({lat, err} !== {32'd2, 1'b0}) begin n_bad++; $display("FAIL push3_resp got lat=%0d err=%0b want lat=2 err=0", lat, err); end
    issue(0, 2'b01, 3'd0, 4'h7, ack, scmd, swen, swd, lat, err, rd);
    n_cmp++; if ({scmd, swen, swd} !== {2'b01, 1'b1, 4'h7}) begin n_bad++; $display("FAIL push7_stk got=%b want=0110111", {scmd, swen, swd}); end
    n_cmp++; if ({lat, err, rd} !== {32'd2, 1'b0, 4'h0}) begin n_bad++; $display("FAIL push7_resp got lat=%0d err=%0b rd=%0h want 2/0/0", lat, err, rd); end
    n_cmp++; if (dut.count !== 3'd2) begin n_bad++; $display("FAIL push_count got=%0d want=2", dut.count); end
  endtask

  task automatic test_get();
    issue(0, 2'b11, 3'd0, 4'h0, ack, scmd, swen, swd, lat, err, rd);
    n_cmp++; if ({scmd, swen} !== {2'b11, 1'b0}) begin n_bad++; $display("FAIL get0_stk got=%b want=110", {scmd, swen}); end
    n_cmp++; if ({lat, err, rd} !== {32'd2, 1'b0, 4'h7}) begin n_bad++; $display("FAIL get0_resp got lat=%0d err=%0b rd=%0h want 2/0/7", lat, err, rd); end
    issue(0, 2'b11, 3'd1, 4'h0, ack, scmd, swen, swd, lat, err, rd);
    n_cmp++; if ({lat, err, rd} !== {32'd2, 1'b0, 4'h3}) begin n_bad++; $display("FAIL get1_resp got lat=%0d err=%0b rd=%0h want 2/0/3", lat, err, rd); end
    issue(0, 2'b11, 3'd2, 4'h0, ack, scmd, swen, swd, lat, err, rd);
    n_cmp++; if (scmd !== 2'b00) begin n_bad++; $display("FAIL get2_stk got=%b want=00", scmd); end
    n_cmp++; if ({lat, err, rd} !== {32'd1, 1'b1, 4'h0}) begin n_bad++; $display("FAIL get2_resp got lat=%0d err=%0b rd=%0h want 1/1/0", lat, err, rd); end
    n_cmp++; if (dut.count !== 3'd2) begin n_bad++; $display("FAIL get_count got=%0d want=2", dut.count); end
  endtask

  task automatic test_back_to_back();
    bit owners[$];
    bit errs[$];
    bit exp_b;
    do_reset();
    bus.req_a = 1; bus.cmd_a = 2'b01; bus.wdata_a = 4'h1;
    bus.req_b = 1; bus.cmd_b = 2'b01; bus.wdata_b = 4'h2;
    for (int cyc = 0; cyc < 40 && errs.size() < 6; cyc++) begin
      @(negedge clk);
      if (bus.ack_a) owners.push_back(1'b0);
      if (bus.ack_b) owners.push_back(1'b1);
      if (bus.rvalid_a || bus.rvalid_b) errs.push_back(bus.rerr);
      @(posedge clk); #1;
    end
    idle_inputs();
    n_cmp++; if (owners.size() !== 6 || errs.size() !== 6) begin n_bad++; $display("FAIL b2b_count got acks=%0d resps=%0d want 6/6", owners.size(), errs.size()); end
    for (int k = 0; k < 6 && k < owners.size() && k < errs.size(); k++) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
      exp_b = 1'b0;
`else
      exp_b = (k % 2) == 1;
`endif
      n_cmp++; if (owners[k] !== exp_b) begin n_bad++; $display("FAIL b2b_owner%0d got=%0b want=%0b", k, owners[k], exp_b); end
      n_cmp++; if (errs[k] !== (k == 5)) begin n_bad++; $display("FAIL b2b_err%0d got=%0b want=%0b", k, errs[k], k == 5); end
    end
    n_cmp++; if (dut.count !== 3'd5) begin n_bad++; $display("FAIL b2b_full_count got=%0d want=5", dut.count); end
    @(posedge clk); #1;
  endtask

  task automatic test_empty_pop();
    do_reset();
    issue(1, 2'b10, 3'd0, 4'h0, ack, scmd, swen, swd, lat, err, rd);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL pop_empty_ack got=%0b want=1", ack); end
    n_cmp++; if (scmd !== 2'b00) begin n_bad++; $display("FAIL pop_empty_stk got=%b want=00", scmd); end
    n_cmp++; if ({lat, err} !== {32'd1, 1'b1}) begin n_bad++; $display("FAIL pop_empty_resp got lat=%0d err=%0b want 1/1", lat, err); end
    issue(1, 2'b01, 3'd0, 4'hC, ack, scmd, swen, swd, lat, err, rd);
    n_cmp++; if ({lat, err} !== {32'd2, 1'b0}) begin n_bad++; $display("FAIL pushC_resp got lat=%0d err=%0b want 2/0", lat, err); end
    issue(1, 2'b10, 3'd0, 4'h0, ack, scmd, swen, swd, lat, err, rd);
    n_cmp++; if (scmd !== 2'b10) begin n_bad++; $display("FAIL popC_stk got=%b want=10", scmd); end
    n_cmp++; if ({lat, err, rd} !== {32'd2, 1'b0, 4'hC}) begin n_bad++; $display("FAIL popC_resp got lat=%0d err=%0b rd=%0h want 2/0/c", lat, err, rd); end
    n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL popC_count got=%0d want=0", dut.count); end
  endtask

  task automatic test_reset_mid_issue();
    bit seen_rv;
    do_reset();
    bus.req_a = 1; bus.cmd_a = 2'b01; bus.wdata_a = 4'h5;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (stk_cmd !== 2'b01) begin n_bad++; $display("FAIL mid_issue_stk got=%b want=01", stk_cmd); end
    reset = 0;
    @(posedge clk); #1;
    seen_rv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.rvalid_a || bus.rvalid_b) seen_rv = 1;
      if (k == 0) begin
        n_cmp++; if (stk_clr !== 1'b1) begin n_bad++; $display("FAIL mid_clr got=%0b want=1", stk_clr); end
        n_cmp++; if (bus.ack_a !== 1'b0) begin n_bad++; $display("FAIL mid_ack got=%0b want=0", bus.ack_a); end
        n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL mid_count got=%0d want=0", dut.count); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (seen_rv !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid got=%0b want=0", seen_rv); end
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_arb_four();
    bit owners[$];
    bit exp_b;
    int nresp;
    do_reset();
    bus.req_a = 1; bus.cmd_a = 2'b00;
    bus.req_b = 1; bus.cmd_b = 2'b00;
    nresp = 0;
    for (int cyc = 0; cyc < 30 && owners.size() < 4; cyc++) begin
      @(negedge clk);
      if (bus.ack_a) owners.push_back(1'b0);
      if (bus.ack_b) owners.push_back(1'b1);
      if ((bus.rvalid_a || bus.rvalid_b) && !bus.rerr && bus.rdata == 4'h0) nresp++;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    if ((bus.rvalid_a || bus.rvalid_b) && !bus.rerr && bus.rdata == 4'h0) nresp++;
    @(posedge clk); #1;
    n_cmp++; if (owners.size() !== 4) begin n_bad++; $display("FAIL arb4_acks got=%0d want=4", owners.size()); end
    n_cmp++; if (nresp !== 4) begin n_bad++; $display("FAIL arb4_nop_resps got=%0d want=4", nresp); end
    for (int k = 0; k < 4 && k < owners.size(); k++) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
      exp_b = 1'b0;
`else
      exp_b = (k % 2) == 1;
`endif
      n_cmp++; if (owners[k] !== exp_b) begin n_bad++; $display("FAIL arb4_owner%0d got=%0b want=%0b", k, owners[k], exp_b); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 0;
    idle_inputs();
    test_reset();
    test_push();
    test_get();
    test_back_to_back();
    test_empty_pop();
    test_reset_mid_issue();
    test_arb_four();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
